// File: rtl/and8_gate.sv
// and8_gate: registered bitwise AND of two operand vectors.
//
// Samples in1 and in2 on every rising clk edge and presents in1 & in2 on
// out one cycle later. No enable and no handshake: a new result is
// captured every cycle. Reset is synchronous and active-high and clears
// the result register to all zeros.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   in1  - first operand vector (WIDTH bits)
//   in2  - second operand vector (WIDTH bits)
//   out  - registered result, out[i] = in1[i] & in2[i]
module and8_gate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Per-bit AND; bits are independent so X/Z stays confined to its own lane.
    always_comb begin
        out_d = in1 & in2;
    end

    // Result register; reset wins over the incoming operands at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Output is driven only from the register, never from the operands.
    assign out = out_q;

endmodule

// File: tb/tb_and8_gate.sv
// Directed self-checking bench for and8_gate (WIDTH = 8).
module tb_and8_gate;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;

    int n_vec;
    int n_bad;

    and8_gate #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .in1 (in1),
        .in2 (in2),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: out=0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, settle 1 time unit past the edge.
    task automatic step(input logic r, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
        rst = r;
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] bit_v;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        in1   = 8'hFF;
        in2   = 8'hFF;

        // Reset held for two edges with all-ones operands.
        step(1'b1, 8'hFF, 8'hFF);
        check_eq("reset_edge1", out, 8'h00);
        step(1'b1, 8'hFF, 8'hFF);
        check_eq("reset_edge2", out, 8'h00);
        step(1'b0, 8'hFF, 8'hFF);
        check_eq("reset_release", out, 8'hFF);

        // Basic patterns.
        step(1'b0, 8'h33, 8'hCC);
        check_eq("complementary", out, 8'h00);
        step(1'b0, 8'hAA, 8'hF0);
        check_eq("partial_overlap", out, 8'hA0);
        step(1'b0, 8'h5A, 8'hFF);
        check_eq("identity", out, 8'h5A);
        step(1'b0, 8'h5A, 8'h00);
        check_eq("annihilator", out, 8'h00);

        // Back-to-back edges.
        step(1'b0, 8'h33, 8'hCC);
        check_eq("b2b_0", out, 8'h00);
        step(1'b0, 8'hAA, 8'hF0);
        check_eq("b2b_1", out, 8'hA0);
        step(1'b0, 8'hFF, 8'h81);
        check_eq("b2b_2", out, 8'h81);

        // Mid-stream reset discards the result due at that edge.
        step(1'b1, 8'hFF, 8'hFF);
        check_eq("midrst_assert", out, 8'h00);
        step(1'b0, 8'hFF, 8'hFF);
        check_eq("midrst_release", out, 8'hFF);

        // Operand change between edges must not reach out.
        in1 = 8'h00;
        #2;
        check_eq("between_edge_in1", out, 8'hFF);
        @(posedge clk);
        #1;
        check_eq("in1_change_taken", out, 8'h00);

        // Reset raised between edges only acts at the next edge.
        step(1'b0, 8'hC3, 8'hF3);
        check_eq("pre_async_rst", out, 8'hC3);
        rst = 1'b1;
        in1 = 8'hFF;
        in2 = 8'hFF;
        #2;
        check_eq("rst_between_edges", out, 8'hC3);
        @(posedge clk);
        #1;
        check_eq("rst_at_edge", out, 8'h00);

        // Walking one on in1 and walking zero on in2: lanes are independent.
        for (int i = 0; i < int'(WIDTH); i++) begin
            bit_v = WIDTH'(1) << i;
            step(1'b0, bit_v, 8'hFF);
            check_eq($sformatf("walk1_b%0d", i), out, bit_v);
            step(1'b0, 8'hFF, ~bit_v);
            check_eq($sformatf("walk0_b%0d", i), out, ~bit_v);
        end

        // Assorted hand-computed vectors.
        step(1'b0, 8'h0F, 8'h3C);
        check_eq("mix_0F_3C", out, 8'h0C);
        step(1'b0, 8'h96, 8'h69);
        check_eq("mix_96_69", out, 8'h00);
        step(1'b0, 8'hE7, 8'h7E);
        check_eq("mix_E7_7E", out, 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
